// File: rtl/uart_response_tx_if.sv
// Parser-side handshake and UART line signals for uart_response_tx.
// master = event producer / line observer, slave = the transmitter.
interface uart_response_tx_if;
  logic       i_evt_valid;
  logic [1:0] i_evt_code;
  logic [7:0] i_led;
  logic       o_evt_ready;
  logic       o_tx_serial;
  logic       o_tx_active;
  logic       o_tx_done;

  modport master (
    output i_evt_valid, i_evt_code, i_led,
    input  o_evt_ready, o_tx_serial, o_tx_active, o_tx_done
  );

  modport slave (
    input  i_evt_valid, i_evt_code, i_led,
    output o_evt_ready, o_tx_serial, o_tx_active, o_tx_done
  );
endinterface

// File: rtl/uart_response_tx.sv
// Formats a parser result event as an ASCII reply line and sends it 8N1.
// Define UART_RESP_STATUS_EN to build the "L=hh" STATUS reply for code 2.
module uart_response_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input logic              clk,
  input logic              rst,
  uart_response_tx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [2:0]    r_byte;
  logic [1:0]    r_code;
  logic          r_tx;
  logic          r_ready;
  logic          r_active;
  logic          r_done;
`ifdef UART_RESP_STATUS_EN
  logic [7:0]    r_led;
`endif

  logic [7:0] w_byte;
  logic [2:0] w_last;
  logic       w_baud_end;
  logic       w_accept;

  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_accept   = bus.i_evt_valid & r_ready;

`ifdef UART_RESP_STATUS_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  // Reply ROM indexed by the latched code and the current byte position.
  always_comb begin
    w_byte = 8'h0A;
    w_last = 3'd3;
    case (r_code)
      2'd1, 2'd3: begin
        w_last = 3'd4;
        case (r_byte)
          3'd0:    w_byte = 8'h45;
          3'd1:    w_byte = 8'h52;
          3'd2:    w_byte = 8'h52;
          3'd3:    w_byte = 8'h0D;
          default: w_byte = 8'h0A;
        endcase
      end
`ifdef UART_RESP_STATUS_EN
      2'd2: begin
        w_last = 3'd5;
        case (r_byte)
          3'd0:    w_byte = 8'h4C;
          3'd1:    w_byte = 8'h3D;
          3'd2:    w_byte = hex_ascii(r_led[7:4]);
          3'd3:    w_byte = hex_ascii(r_led[3:0]);
          3'd4:    w_byte = 8'h0D;
          default: w_byte = 8'h0A;
        endcase
      end
`endif
      default: begin
        w_last = 3'd3;
        case (r_byte)
          3'd0:    w_byte = 8'h4F;
          3'd1:    w_byte = 8'h4B;
          3'd2:    w_byte = 8'h0D;
          default: w_byte = 8'h0A;
        endcase
      end
    endcase
  end

  // The line is driven from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_code   <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_RESP_STATUS_EN
      r_led    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) r_baud <= '0;
      else                   r_baud <= w_baud_end ? '0 : r_baud + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_state  <= S_START;
            r_code   <= bus.i_evt_code;
`ifdef UART_RESP_STATUS_EN
            r_led    <= bus.i_led;
`endif
            r_byte   <= '0;
            r_bit    <= '0;
            r_ready  <= 1'b0;
            r_active <= 1'b1;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_baud_end) r_state <= S_DATA;
        end
        S_DATA: begin
          r_tx <= w_byte[r_bit];
          if (w_baud_end) begin
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            if (r_byte == w_last) begin
              r_state  <= S_IDLE;
              r_byte   <= '0;
              r_done   <= 1'b1;
              r_ready  <= 1'b1;
              r_active <= 1'b0;
            end else begin
              r_byte  <= r_byte + 3'd1;
              r_state <= S_START;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_evt_ready = r_ready;
  assign bus.o_tx_serial = r_tx;
  assign bus.o_tx_active = r_active;
  assign bus.o_tx_done   = r_done;
endmodule

// File: tb/tb_uart_response_tx.sv
// Bench for uart_response_tx: message-level reference model, per-cycle output
// comparison, a mid-bit sampling UART receiver and directed reply scenarios.
module tb_uart_response_tx;
  localparam int CPB = 87;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  uart_response_tx_if bus ();

  uart_response_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Reference model: a message is a list of bytes; the line is derived from
  // the number of cycles elapsed since the accept edge.
  bit         m_live = 0;
  bit         m_done = 0;
  bit         m_acc = 0;
  int         m_acc_cyc = 0;
  int         m_rem = 0;
  int         m_j = -1;
  int         m_total = 0;
  int         rst_gen = 0;
  logic [7:0] m_msg[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  function automatic logic exp_line();
    int bi, by, w;
    logic [7:0] bt;
    if (m_j < 1 || m_j > m_total) return 1'b1;
    bi = (m_j - 1) / CPB;
    by = bi / 10;
    w  = bi % 10;
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    bt = m_msg[by];
    return bt[w-1];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    m_acc = 0;
    if (rst) begin
      m_live = 1;
      m_rem  = 0;
      m_j    = -1;
      m_done = 0;
      m_msg.delete();
      exp_q.delete();
      rst_gen++;
    end else begin
      m_done = (m_rem == 1);
      if (m_rem > 0) begin
        m_rem--;
        m_j++;
      end else if (bus.i_evt_valid) begin
        m_msg.delete();
        case (bus.i_evt_code)
          2'd0: m_msg = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
`ifdef UART_RESP_STATUS_EN
          2'd2: m_msg = '{8'h4C, 8'h3D, hexc(int'(bus.i_led[7:4])), hexc(int'(bus.i_led[3:0])), 8'h0D, 8'h0A};
`else
          2'd2: m_msg = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
`endif
          default: m_msg = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
        endcase
        foreach (m_msg[i]) exp_q.push_back(m_msg[i]);
        m_total   = m_msg.size() * 10 * CPB;
        m_rem     = m_total;
        m_j       = 0;
        m_acc     = 1;
        m_acc_cyc = cyc;
      end else if (m_j >= 0) begin
        m_j++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("ready",  bus.o_evt_ready, (m_rem == 0) ? 1 : 0);
      check("active", bus.o_tx_active, (m_rem > 0) ? 1 : 0);
      check("done",   bus.o_tx_done,   m_done ? 1 : 0);
      check("line",   bus.o_tx_serial, exp_line());
    end
  end

  // UART receiver sampling at mid-bit; bytes cut short by a reset are dropped.
  initial forever begin
    logic [7:0] b;
    logic       stop_bit;
    int         g;
    @(negedge clk);
    if (bus.o_tx_serial === 1'b0) begin
      g = rst_gen;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = bus.o_tx_serial;
      end
      repeat (CPB) @(negedge clk);
      stop_bit = bus.o_tx_serial;
      if (g == rst_gen) begin
        check("rx_stop", stop_bit, 1);
        if (exp_q.size() == 0) fail("rx_unexpected_byte");
        else check("rx_byte", b, exp_q.pop_front());
        rx_log.push_back(b);
      end
    end
  end

  task automatic send_evt(input logic [1:0] code, input logic [7:0] led,
                          input int budget, output int acc);
    bus.i_evt_valid = 1'b1;
    bus.i_evt_code  = code;
    bus.i_led       = led;
    acc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_acc) begin
        acc = m_acc_cyc;
        break;
      end
    end
    if (acc < 0) fail("accept");
    bus.i_evt_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_tx_done === 1'b1) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) fail("done_wait");
  endtask

  task automatic expect_rx(input string name, input logic [79:0] e, input int n);
    check({name, "_len"}, rx_log.size(), n);
    for (int i = 0; i < n && i < rx_log.size(); i++)
      check(name, rx_log[i], e[79-8*i -: 8]);
    rx_log.delete();
  endtask

  initial begin
    int acc, acc2, d, d1, fall, dones;
    bus.i_evt_valid = 1'b0;
    bus.i_evt_code  = 2'd0;
    bus.i_led       = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (1000) @(negedge clk);
    check("t1_ready", bus.o_evt_ready, 1);
    check("t1_line", bus.o_tx_serial, 1);
    check("t1_active", bus.o_tx_active, 0);

    // OK reply and its exact length
    send_evt(2'd0, 8'h00, 10, acc);
    wait_done(4000, d);
    check("t2_done_latency", d - acc, 3480);
    repeat (20) @(negedge clk);
    check("t2_ready", bus.o_evt_ready, 1);
    expect_rx("t2_rx", {32'h4F4B0D0A, 48'h0}, 4);

`ifdef UART_RESP_STATUS_EN
    // STATUS with LED snapshot; the live LED changes right after accept
    send_evt(2'd2, 8'hA5, 10, acc);
    bus.i_led = 8'h00;
    wait_done(6000, d);
    check("t3_done_latency", d - acc, 5220);
    repeat (20) @(negedge clk);
    expect_rx("t3_rx", {48'h4C3D41350D0A, 32'h0}, 6);
`else
    // Code 2 falls back to OK
    send_evt(2'd2, 8'h03, 10, acc);
    wait_done(4000, d);
    check("t6_done_latency", d - acc, 3480);
    repeat (20) @(negedge clk);
    expect_rx("t6_rx", {32'h4F4B0D0A, 48'h0}, 4);
`endif

    // Back-to-back: second event held while busy
    send_evt(2'd1, 8'h00, 10, acc);
    fork
      send_evt(2'd0, 8'h00, 5000, acc2);
      wait_done(5000, d1);
    join
    check("t4_first_len", d1 - acc, 4350);
    check("t4_accept_gap", acc2 - d1, 1);
    fall = -1;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_tx_serial === 1'b0) begin
        fall = cyc;
        break;
      end
      @(negedge clk);
    end
    check("t4_start_gap", fall - d1, 2);
    wait_done(4000, d);
    check("t4_second_len", d - acc2, 3480);
    repeat (20) @(negedge clk);
    expect_rx("t4_rx", 80'h4552520D0A4F4B0D0A00, 9);

    // Reset during the second byte's data bits
    send_evt(2'd0, 8'h00, 10, acc);
    repeat (10 * CPB + 4 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_line", bus.o_tx_serial, 1);
    check("t5_ready", bus.o_evt_ready, 1);
    check("t5_active", bus.o_tx_active, 0);
    rx_log.delete();
    dones = 0;
    repeat (3600) begin
      @(negedge clk);
      if (bus.o_tx_done === 1'b1) dones++;
    end
    check("t5_no_done", dones, 0);
    check("t5_rx_quiet", rx_log.size(), 0);
    send_evt(2'd3, 8'h00, 10, acc);
    wait_done(5000, d);
    check("t5_done_latency", d - acc, 4350);
    repeat (20) @(negedge clk);
    expect_rx("t5_rx", {40'h4552520D0A, 40'h0}, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(100 * 80000);
    n_errors++;
    $display("FAIL watchdog: simulation exceeded cycle limit at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule
